// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;
  localparam int NUM_PORTS  = 2;
endpackage

// File: rtl/mem_arbiter_arb_rr_sel.sv
// Two-requester winner selection: round-robin by pointer, or fixed priority to port 0.
module arb_rr_sel (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  input  logic       mode,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) gnt = (mode || !ptr) ? 2'b01 : 2'b10;
    else if (req0)    gnt = 2'b01;
    else if (req1)    gnt = 2'b10;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-cycle data memory; one access per two cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [31:0]      p0_addr,
  input  logic [31:0]      p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [31:0]      p0_rdata,
  output logic             p0_err,
  output logic [CNT_W-1:0] p0_cnt,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [31:0]      p1_addr,
  input  logic [31:0]      p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [31:0]      p1_rdata,
  output logic             p1_err,
  output logic [CNT_W-1:0] p1_cnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             mem_rd,
  input  logic [31:0]      mem_rdata
);
  state_t      state, nextState;
  logic        rrPtr;
  logic [1:0]  sel;
  logic [1:0]  gnt;
  logic        cmdWe, cmdPort;
  logic [31:0] cmdAddr, cmdWdata;
  logic [31:0] memAddrQ, memWdataQ;
  logic        winWe;
  logic [31:0] winAddr, winWdata;
  logic        inAccess, aligned;

  logic [NUM_PORTS-1:0]            rvalid, err;
  logic [NUM_PORTS-1:0][31:0]      rdata;
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;

  arb_rr_sel uSel (
    .req0 (p0_req),
    .req1 (p1_req),
    .ptr  (rrPtr),
    .mode (PRIO_MODE == PRIO_FIXED),
    .gnt  (sel)
  );

  assign winWe    = sel[1] ? p1_we    : p0_we;
  assign winAddr  = sel[1] ? p1_addr  : p0_addr;
  assign winWdata = sel[1] ? p1_wdata : p0_wdata;

  always_comb begin
    nextState = state;
    gnt       = 2'b00;
    case (state)
      IDLE: if (sel != 2'b00) begin
        gnt       = sel;
        nextState = ACCESS;
      end
      ACCESS: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rrPtr     <= 1'b0;
      cmdWe     <= 1'b0;
      cmdPort   <= 1'b0;
      cmdAddr   <= '0;
      cmdWdata  <= '0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
    end else begin
      state <= nextState;
      if (gnt != 2'b00) begin
        rrPtr    <= gnt[0];
        cmdWe    <= winWe;
        cmdPort  <= gnt[1];
        cmdAddr  <= winAddr;
        cmdWdata <= winWdata;
        // misaligned commands never reach the memory bus, so its lines keep their old values
        if (winAddr[1:0] == 2'b00) begin
          memAddrQ  <= winAddr;
          memWdataQ <= winWdata;
        end
      end
    end
  end

  assign inAccess  = (state == ACCESS);
  assign aligned   = (cmdAddr[1:0] == 2'b00);
  assign mem_we    = inAccess && aligned && cmdWe;
  assign mem_rd    = inAccess && aligned && !cmdWe;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : gPort
    logic mine;
    assign mine = inAccess && (cmdPort == 1'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rvalid[i] <= 1'b0;
        err[i]    <= 1'b0;
        rdata[i]  <= '0;
        cnt[i]    <= '0;
      end else begin
        rvalid[i] <= mine;
        if (mine) begin
          err[i]   <= !aligned;
          rdata[i] <= (aligned && !cmdWe) ? mem_rdata : 32'h0;
        end
        if (gnt[i] && cnt[i] != {CNT_W{1'b1}}) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];
  assign p0_cnt    = cnt[0];
  assign p1_cnt    = cnt[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (a_*) and fixed-priority CNT_W=4 instance (b_*).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  logic        a_p0_req = 0, a_p0_we = 0, a_p1_req = 0, a_p1_we = 0;
  logic [31:0] a_p0_addr = 0, a_p0_wdata = 0, a_p1_addr = 0, a_p1_wdata = 0;
  logic        a_p0_gnt, a_p0_rvalid, a_p0_err, a_p1_gnt, a_p1_rvalid, a_p1_err;
  logic [31:0] a_p0_rdata, a_p1_rdata;
  logic [15:0] a_p0_cnt, a_p1_cnt;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_we, a_mem_rd;

  logic        b_p0_req = 0, b_p1_req = 0;
  logic        b_p0_gnt, b_p0_rvalid, b_p0_err, b_p1_gnt, b_p1_rvalid, b_p1_err;
  logic [31:0] b_p0_rdata, b_p1_rdata;
  logic [3:0]  b_p0_cnt, b_p1_cnt;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic        b_mem_we, b_mem_rd;

  logic [31:0] memA [0:255];
  assign a_mem_rdata = memA[a_mem_addr[9:2]];
  always @(posedge clk) if (a_mem_we) memA[a_mem_addr[9:2]] <= a_mem_wdata;

  mem_arbiter #(.PRIO_MODE(0), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata), .p0_err(a_p0_err), .p0_cnt(a_p0_cnt),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata), .p1_err(a_p1_err), .p1_cnt(a_p1_cnt),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rd(a_mem_rd),
    .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.PRIO_MODE(1), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(1'b0), .p0_addr(32'h0), .p0_wdata(32'h0),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata), .p0_err(b_p0_err), .p0_cnt(b_p0_cnt),
    .p1_req(b_p1_req), .p1_we(1'b0), .p1_addr(32'h4), .p1_wdata(32'h0),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err), .p1_cnt(b_p1_cnt),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rd(b_mem_rd),
    .mem_rdata(32'h0)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++;
    if ({a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_p0_err, a_p1_err, a_mem_we, a_mem_rd} !== 8'h0) begin
      bad++; $display("FAIL reset_ctrlA got %b want 00000000",
        {a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_p0_err, a_p1_err, a_mem_we, a_mem_rd});
    end
    vec++;
    if ({a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata, a_p0_cnt, a_p1_cnt} !== '0) begin
      bad++; $display("FAIL reset_dataA rdata0=%h rdata1=%h addr=%h wdata=%h cnt0=%0d cnt1=%0d want all 0",
        a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata, a_p0_cnt, a_p1_cnt);
    end
    vec++;
    if ({b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid, b_mem_we, b_mem_rd, b_p0_cnt, b_p1_cnt} !== '0) begin
      bad++; $display("FAIL reset_B got nonzero ctrl/cnt cnt0=%0d cnt1=%0d want 0", b_p0_cnt, b_p1_cnt);
    end
    step(); rst = 1'b0;
  endtask

  task automatic test_write_read();
    step();
    a_p0_req = 1; a_p0_we = 1; a_p0_addr = 32'h10; a_p0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    vec++; if (a_p0_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got %b want 1", a_p0_gnt); end
    step(); a_p0_req = 0;
    @(negedge clk);
    vec++;
    if (a_mem_we !== 1'b1 || a_mem_rd !== 1'b0 || a_mem_addr !== 32'h10 || a_mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_mem we=%b rd=%b addr=%h wdata=%h want 1 0 00000010 deadbeef",
        a_mem_we, a_mem_rd, a_mem_addr, a_mem_wdata);
    end
    step();
    a_p0_req = 1; a_p0_we = 0; a_p0_addr = 32'h10;
    @(negedge clk);
    vec++;
    if (a_p0_rvalid !== 1'b1 || a_p0_err !== 1'b0 || a_p0_gnt !== 1'b1) begin
      bad++; $display("FAIL wr_done_rd_gnt rvalid=%b err=%b gnt=%b want 1 0 1", a_p0_rvalid, a_p0_err, a_p0_gnt);
    end
    step(); a_p0_req = 0;
    @(negedge clk);
    vec++;
    if (a_mem_rd !== 1'b1 || a_mem_we !== 1'b0 || a_p0_rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_mem rd=%b we=%b rvalid=%b want 1 0 0", a_mem_rd, a_mem_we, a_p0_rvalid);
    end
    step(); @(negedge clk);
    vec++;
    if (a_p0_rvalid !== 1'b1 || a_p0_rdata !== 32'hDEADBEEF || a_p0_err !== 1'b0) begin
      bad++; $display("FAIL rd_data rvalid=%b rdata=%h err=%b want 1 deadbeef 0", a_p0_rvalid, a_p0_rdata, a_p0_err);
    end
    step();
  endtask

  task automatic test_misaligned();
    a_p1_req = 1; a_p1_we = 1; a_p1_addr = 32'h13; a_p1_wdata = 32'h12345678;
    @(negedge clk);
    vec++; if (a_p1_gnt !== 1'b1) begin bad++; $display("FAIL mis_gnt got %b want 1", a_p1_gnt); end
    step(); a_p1_req = 0;
    @(negedge clk);
    vec++;
    if (a_mem_we !== 1'b0 || a_mem_rd !== 1'b0) begin
      bad++; $display("FAIL mis_mem we=%b rd=%b want 0 0", a_mem_we, a_mem_rd);
    end
    step(); @(negedge clk);
    vec++;
    if (a_p1_rvalid !== 1'b1 || a_p1_err !== 1'b1 || a_p1_rdata !== 32'h0) begin
      bad++; $display("FAIL mis_resp rvalid=%b err=%b rdata=%h want 1 1 00000000", a_p1_rvalid, a_p1_err, a_p1_rdata);
    end
    vec++;
    if (memA[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_word got %h want deadbeef", memA[4]); end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] expG;
    rst = 1'b1;
    a_p0_req = 1; a_p0_we = 0; a_p0_addr = 32'h0;
    a_p1_req = 1; a_p1_we = 0; a_p1_addr = 32'h4;
    step(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      expG = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
      vec++;
      if ({a_p1_gnt, a_p0_gnt} !== expG) begin
        bad++; $display("FAIL rr_gnt cycle %0d got %b want %b", k, {a_p1_gnt, a_p0_gnt}, expG);
      end
      step();
    end
    a_p0_req = 0; a_p1_req = 0;
    @(negedge clk);
    vec++;
    if (a_p0_cnt !== 16'd2 || a_p1_cnt !== 16'd2) begin
      bad++; $display("FAIL rr_cnt cnt0=%0d cnt1=%0d want 2 2", a_p0_cnt, a_p1_cnt);
    end
    step(); step();
  endtask

  task automatic test_reset_mid_access();
    a_p0_req = 1; a_p0_we = 1; a_p0_addr = 32'h20; a_p0_wdata = 32'hAAAA5555;
    step(); a_p0_req = 0;
    step(); step();
    vec++;
    if (memA[8] !== 32'hAAAA5555) begin bad++; $display("FAIL rst_setup got %h want aaaa5555", memA[8]); end
    a_p0_req = 1; a_p0_wdata = 32'h12345678;
    step(); a_p0_req = 0;
    @(negedge clk);
    vec++; if (a_mem_we !== 1'b1) begin bad++; $display("FAIL rst_pre_we got %b want 1", a_mem_we); end
    #1 rst = 1'b1;
    #1;
    vec++; if (a_mem_we !== 1'b0) begin bad++; $display("FAIL rst_we_drop got %b want 0", a_mem_we); end
    step(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (a_p0_rvalid !== 1'b0) begin bad++; $display("FAIL rst_no_rvalid cycle %0d got 1 want 0", k); end
      step();
    end
    vec++;
    if (memA[8] !== 32'hAAAA5555 || a_p0_cnt !== 16'd0 || a_p1_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_after word=%h cnt0=%0d cnt1=%0d want aaaa5555 0 0", memA[8], a_p0_cnt, a_p1_cnt);
    end
  endtask

  task automatic test_fixed_prio();
    int g0 = 0;
    b_p0_req = 1; b_p1_req = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b_p0_gnt === 1'b1) g0++;
      vec++;
      if (b_p1_gnt !== 1'b0) begin bad++; $display("FAIL prio_p1_gnt cycle %0d got 1 want 0", k); end
      step();
    end
    b_p0_req = 0; b_p1_req = 0;
    @(negedge clk);
    vec++;
    if (g0 != 6 || b_p0_cnt !== 4'd6 || b_p1_cnt !== 4'd0) begin
      bad++; $display("FAIL prio_cnt grants0=%0d cnt0=%0d cnt1=%0d want 6 6 0", g0, b_p0_cnt, b_p1_cnt);
    end
    step(); step();
  endtask

  task automatic test_saturation();
    b_p1_req = 1;
    repeat (28) step();
    @(negedge clk);
    vec++;
    if (b_p1_cnt !== 4'd14) begin bad++; $display("FAIL sat_pre got %0d want 14", b_p1_cnt); end
    repeat (12) step();
    b_p1_req = 0;
    @(negedge clk);
    vec++;
    if (b_p1_cnt !== 4'd15 || b_p0_cnt !== 4'd6) begin
      bad++; $display("FAIL sat_cnt cnt1=%0d cnt0=%0d want 15 6", b_p1_cnt, b_p0_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memA[i] = 32'h0;
    test_reset();
    test_write_read();
    test_misaligned();
    test_round_robin();
    test_reset_mid_access();
    test_fixed_prio();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0, SHALL select arbitration: 0 = round-robin, 1 = fixed priority to port 0.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the per-port grant counters.
REQ-003 clk  input  1  single clock for all state; reset is asynchronous and active-high.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 pN_req  input  1  N in {0,1}; port N access request, held until pN_gnt (port 0 = load/store unit, port 1 = DMA/debug).
REQ-006 pN_we  input  1  1 = write, 0 = read; sampled in the grant cycle.
REQ-007 pN_addr  input  32  byte address; sampled in the grant cycle.
REQ-008 pN_wdata  input  32  write data; sampled in the grant cycle.
REQ-009 pN_gnt  output  1  one-cycle pulse; the command is accepted this cycle.
REQ-010 pN_rvalid  output  1  one-cycle completion pulse, for both reads and writes.
REQ-011 pN_rdata  output  32  read data; valid while pN_rvalid is high.
REQ-012 pN_err  output  1  qualifies pN_rvalid; marks a misaligned access.
REQ-013 pN_cnt  output  CNT_W  saturating count of grants to port N.
REQ-014 mem_addr  output  32  word-aligned address to the data memory.
REQ-015 mem_wdata  output  32  write data to the data memory.
REQ-016 mem_we  output  1  data memory write enable; the write commits on the rising clk edge.
REQ-017 mem_rd  output  1  data memory read enable.
REQ-018 mem_rdata  input  32  combinational read data from the data memory.

Function
REQ-019 FSM SHALL have two states: IDLE and ACCESS.
REQ-020 IDLE, no pN_req: stay in IDLE with all gnt low.
REQ-021 IDLE, at least one request: select a winner, pulse its gnt combinationally, latch we/addr/wdata/port, go to ACCESS.
REQ-022 Round-robin mode, both requests: the port indicated by the rr pointer wins; after any grant the pointer points to the other port.
REQ-023 Round-robin mode, single request: that port wins regardless of the pointer.
REQ-024 PRIO_MODE=1: port 0 always wins when both request.
REQ-025 ACCESS, aligned address (addr[1:0]==0): drive mem_addr and mem_wdata from the latched command; mem_we = latched we; mem_rd = !latched we.
REQ-026 ACCESS, misaligned address: mem_we = mem_rd = 0, with no memory side effect.
REQ-027 ACCESS end-of-cycle: register mem_rdata into the owning port's rdata (0 for writes and misaligned accesses); set err = misaligned; pulse that port's rvalid in the next cycle; return to IDLE.
REQ-028 Throughput: one access per 2 cycles; a new grant SHALL be allowed in the same cycle as the previous rvalid.
REQ-029 Latency: gnt at cycle T, memory access at T+1, rvalid/rdata at T+2.
REQ-030 Outside ACCESS: mem_we = mem_rd = 0; mem_addr and mem_wdata hold their last values.
REQ-031 pN_cnt SHALL increment on each pN_gnt and saturate at all-ones.
REQ-032 A request withdrawn before gnt SHALL be dropped with no side effect.

Reset
REQ-033 While rst is high, the block SHALL be asynchronously forced to: IDLE; rr pointer = port 0; every gnt, rvalid, err, mem_we and mem_rd = 0; rdata, mem_addr, mem_wdata and cnt = 0.
REQ-034 Reset during ACCESS SHALL abort the access immediately: no write commits and no rvalid is issued.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, ACCESS) and the constants PRIO_RR = 0 and PRIO_FIXED = 1.
REQ-036 Winner selection SHALL be a sub-module arb_rr_sel (inputs: two reqs, pointer, mode; output: one-hot grant).

Verification
REQ-037 Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> p0_gnt at T, mem_we at T+1; read rvalid at T'+2 with rdata = 0xDEADBEEF and err = 0.
REQ-038 Both ports request continuously from reset in round-robin mode -> grant order 0,1,0,1 every 2 cycles; p0_cnt = p1_cnt = 2 after 8 cycles.
REQ-039 PRIO_MODE=1, both ports request continuously -> only p0_gnt pulses; p1_cnt stays 0.
REQ-040 Port 1 writes to 0x13 -> mem_we stays 0; p1_rvalid with p1_err = 1 and p1_rdata = 0; the memory word at 0x10 is unchanged.
REQ-041 rst asserted mid-ACCESS of a write to 0x20 -> mem_we falls immediately; no rvalid; after release the word at 0x20 holds its old value and pN_cnt = 0.
REQ-042 p1_cnt preloaded near saturation with CNT_W=4 -> the count stops at 15.
